// File: rtl/yolo_upsamp_pkg.sv
// rtl/yolo_upsamp_pkg.sv - shared types and sizing helpers for the 2x nearest-neighbour upsampler
package yolo_upsamp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_EMIT_A,
      S_EMIT_B,
      S_DONE
   } upsamp_state_t;

   function automatic int row_words(input int img_w, input int cg);
      return img_w * cg;
   endfunction

   function automatic int frame_in(input int row_w, input int img_h);
      return row_w * img_h;
   endfunction

   // Each input word appears twice horizontally and twice vertically.
   function automatic int frame_out(input int frm_in);
      return 4 * frm_in;
   endfunction

   function automatic int cnt_w(input int terminal);
      return (terminal < 1) ? 1 : $clog2(terminal + 1);
   endfunction

   function automatic int addr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/upsamp_line_buf.sv
// rtl/upsamp_line_buf.sv - one-row line buffer, simple dual-port RAM with registered read
module upsamp_line_buf
   import yolo_upsamp_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 416,
   localparam int AW    = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/yolo_upsamp_stream.sv
// rtl/yolo_upsamp_stream.sv - 2x nearest-neighbour upsampler with ap_* block handshake
module yolo_upsamp_stream
   import yolo_upsamp_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int IMG_W  = 13,
   parameter int IMG_H  = 13,
   parameter int CG     = 32
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              ap_start,
   output logic              ap_done,
   output logic              ap_idle,
   output logic              ap_ready,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic              s_tlast,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic              err_tlast
);

   localparam int ROW_WORDS = row_words(IMG_W, CG);
   localparam int FRAME_IN  = frame_in(ROW_WORDS, IMG_H);
   localparam int FRAME_OUT = frame_out(FRAME_IN);
   localparam int AW = addr_w(ROW_WORDS);
   localparam int RW = cnt_w(IMG_H - 1);
   localparam int CW = cnt_w(IMG_W - 1);
   localparam int GW = cnt_w(CG - 1);
   localparam int IW = cnt_w(FRAME_IN - 1);
   localparam int OW = cnt_w(FRAME_OUT - 1);

   localparam logic [AW-1:0] WR_LAST  = AW'(ROW_WORDS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] C_LAST   = CW'(IMG_W - 1);
   localparam logic [GW-1:0] G_LAST   = GW'(CG - 1);
   localparam logic [IW-1:0] IN_LAST  = IW'(FRAME_IN - 1);
   localparam logic [OW-1:0] OUT_LAST = OW'(FRAME_OUT - 1);

   upsamp_state_t state, state_nxt;

   logic [AW-1:0]     wr_idx, rd_addr;
   logic [RW-1:0]     row;
   logic [CW-1:0]     c;
   logic [GW-1:0]     g;
   logic              rep;
   logic [IW-1:0]     in_cnt;
   logic [OW-1:0]     out_cnt;
   logic              rd_vld, rd_done;
   logic [DATA_W-1:0] rd_data, f0, f1;
   logic              wp, rp;
   logic [1:0]        cnt;
   logic              accept, row_last_word, pop, issue, read_last, drained, emitting;

   assign ap_idle       = (state == S_IDLE);
   assign ap_done       = (state == S_DONE);
   assign s_tready      = (state == S_FILL);
   assign accept        = s_tvalid && s_tready;
   assign row_last_word = accept && (wr_idx == WR_LAST);
   assign ap_ready      = row_last_word && (row == ROW_LAST);

   assign m_tvalid = (cnt != 2'd0);
   assign m_tdata  = rp ? f1 : f0;
   assign m_tlast  = m_tvalid && (out_cnt == OUT_LAST);
   assign pop      = m_tvalid && m_tready;

   // A read is launched only if its data is guaranteed a slot when it lands one cycle later.
   assign emitting  = (state == S_EMIT_A) || ((state == S_EMIT_B) && !rd_done);
   assign issue     = emitting && (({1'b0, cnt} + 3'(rd_vld)) < (3'd2 + 3'(pop)));
   assign read_last = (g == G_LAST) && rep && (c == C_LAST);
   assign rd_addr   = AW'(int'(c) * CG + int'(g));
   assign drained   = rd_done && !rd_vld && (cnt == 2'd1) && pop;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (ap_start) state_nxt = S_FILL;
         S_FILL:   if (row_last_word) state_nxt = S_EMIT_A;
         S_EMIT_A: if (issue && read_last) state_nxt = S_EMIT_B;
         S_EMIT_B: if (drained) state_nxt = (row == ROW_LAST) ? S_DONE : S_FILL;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state     <= S_IDLE;
         wr_idx    <= '0;
         row       <= '0;
         c         <= '0;
         g         <= '0;
         rep       <= 1'b0;
         in_cnt    <= '0;
         out_cnt   <= '0;
         rd_vld    <= 1'b0;
         rd_done   <= 1'b0;
         err_tlast <= 1'b0;
         f0        <= '0;
         f1        <= '0;
         wp        <= 1'b0;
         rp        <= 1'b0;
         cnt       <= 2'd0;
      end else begin
         state <= state_nxt;
         if (ap_idle && ap_start) begin
            err_tlast <= 1'b0;
            row       <= '0;
            wr_idx    <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
         end
         if (accept) begin
            wr_idx <= row_last_word ? '0 : wr_idx + 1'b1;
            in_cnt <= (in_cnt == IN_LAST) ? '0 : in_cnt + 1'b1;
            if (s_tlast != (in_cnt == IN_LAST)) begin
               err_tlast <= 1'b1;
            end
         end
         if (drained) begin
            rd_done <= 1'b0;
            row     <= (row == ROW_LAST) ? '0 : row + 1'b1;
         end
         rd_vld <= issue;
         // Read order per row: column, then repeat, then channel group.
         if (issue) begin
            if (g == G_LAST) begin
               g   <= '0;
               rep <= ~rep;
               if (rep) begin
                  c <= (c == C_LAST) ? '0 : c + 1'b1;
               end
            end else begin
               g <= g + 1'b1;
            end
            if ((state == S_EMIT_B) && read_last) begin
               rd_done <= 1'b1;
            end
         end
         if (rd_vld) begin
            if (wp) f1 <= rd_data;
            else    f0 <= rd_data;
            wp <= ~wp;
         end
         if (pop) begin
            rp      <= ~rp;
            out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + 1'b1;
         end
         cnt <= cnt + 2'(rd_vld) - 2'(pop);
      end
   end

   upsamp_line_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (ROW_WORDS)
   ) u_line_buf (
      .clk   (ap_clk),
      .we    (accept),
      .waddr (wr_idx),
      .wdata (s_tdata),
      .re    (issue),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_yolo_upsamp_stream.sv
// tb/tb_yolo_upsamp_stream.sv - self-checking bench for yolo_upsamp_stream
module tb_yolo_upsamp_stream;

   logic        ap_clk, ap_rst, ap_start, sel;
   logic [63:0] s_tdata;
   logic        s_tvalid, s_tlast, m_tready;

   logic        a_done, a_idle, a_ready, a_s_tready, a_m_tvalid, a_m_tlast, a_err;
   logic        b_done, b_idle, b_ready, b_s_tready, b_m_tvalid, b_m_tlast, b_err;
   logic [63:0] a_m_tdata, b_m_tdata;

   logic        obs_done, obs_idle, obs_ready, obs_s_tready, obs_m_tvalid, obs_m_tlast, obs_err;
   logic [63:0] obs_m_tdata;

   int vectors = 0;
   int miscompares = 0;

   yolo_upsamp_stream #(.DATA_W(64), .IMG_W(2), .IMG_H(2), .CG(2)) u_small (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start && !sel),
      .ap_done(a_done), .ap_idle(a_idle), .ap_ready(a_ready),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid && !sel), .s_tready(a_s_tready), .s_tlast(s_tlast),
      .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(m_tready && !sel), .m_tlast(a_m_tlast),
      .err_tlast(a_err)
   );

   yolo_upsamp_stream #(.DATA_W(64), .IMG_W(13), .IMG_H(13), .CG(32)) u_big (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start && sel),
      .ap_done(b_done), .ap_idle(b_idle), .ap_ready(b_ready),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid && sel), .s_tready(b_s_tready), .s_tlast(s_tlast),
      .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(m_tready && sel), .m_tlast(b_m_tlast),
      .err_tlast(b_err)
   );

   assign obs_done     = sel ? b_done     : a_done;
   assign obs_idle     = sel ? b_idle     : a_idle;
   assign obs_ready    = sel ? b_ready    : a_ready;
   assign obs_s_tready = sel ? b_s_tready : a_s_tready;
   assign obs_m_tvalid = sel ? b_m_tvalid : a_m_tvalid;
   assign obs_m_tlast  = sel ? b_m_tlast  : a_m_tlast;
   assign obs_m_tdata  = sel ? b_m_tdata  : a_m_tdata;
   assign obs_err      = sel ? b_err      : a_err;

   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   // Output word k of the upsampled frame comes from input pixel (oy/2, ox/2).
   function automatic int src_index(input int k, input int w, input int cg);
      int gi, ox, oy;
      gi = k % cg;
      ox = (k / cg) % (2 * w);
      oy = k / (cg * 2 * w);
      return (oy / 2) * w * cg + (ox / 2) * cg + gi;
   endfunction

   task automatic run_frame(input bit big, input int tlast_pos, input int in_pct, input int rdy_pct,
                            input bit hold_start, input bit ramp, input int abort_after);
      int w, h, cg, fin, fout, in_i, out_i, nready, rdy_cyc, done_cyc, cyc, budget;
      logic [63:0] src[$];
      logic [63:0] held, exp_d;
      bit armed, stalled, got_done, exp_err;
      sel = big;
      w = big ? 13 : 2;
      h = big ? 13 : 2;
      cg = big ? 32 : 2;
      fin = w * h * cg;
      fout = 4 * fin;
      exp_err = (tlast_pos != fin - 1);
      for (int i = 0; i < fin; i++) src.push_back(ramp ? 64'(i) : {$urandom, $urandom});
      in_i = 0; out_i = 0; nready = 0; rdy_cyc = 0; done_cyc = 0;
      armed = 0; stalled = 0; got_done = 0; held = '0;
      budget = 400 + fout * 12;
      @(negedge ap_clk);
      vectors++;
      if (obs_idle !== 1'b1) begin
         miscompares++;
         $display("FAIL idle_before_start: ap_idle=%b required 1", obs_idle);
      end
      ap_start = 1'b1;
      cyc = 0;
      while (cyc < budget && !got_done) begin
         if (cyc > 0) @(negedge ap_clk);
         if (abort_after >= 0 && out_i >= abort_after) begin
            ap_rst = 1'b1; ap_start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
            return;
         end
         if (cyc > 0 && !hold_start) ap_start = 1'b0;
         s_tvalid = (in_i < fin) && (int'($urandom_range(99)) < in_pct);
         s_tdata  = '0;
         if (s_tvalid) s_tdata = src[in_i];
         s_tlast  = s_tvalid && (in_i == tlast_pos);
         m_tready = int'($urandom_range(99)) < rdy_pct;
         #1;
         if (cyc > 0) begin
            vectors++;
            if (obs_err !== armed) begin
               miscompares++;
               $display("FAIL err_tlast_track cyc %0d: got %b required %b", cyc, obs_err, armed);
            end
         end
         if (stalled) begin
            vectors++;
            if (obs_m_tvalid !== 1'b1 || obs_m_tdata !== held) begin
               miscompares++;
               $display("FAIL stall_hold word %0d: got valid=%b data=%h required valid=1 data=%h",
                        out_i, obs_m_tvalid, obs_m_tdata, held);
            end
         end
         if (obs_ready === 1'b1) begin nready++; rdy_cyc = cyc; end
         if (obs_done === 1'b1) begin got_done = 1; done_cyc = cyc; end
         if (s_tvalid && obs_s_tready === 1'b1) begin
            if (s_tlast != (in_i == fin - 1)) armed = 1;
            in_i++;
         end
         if (obs_m_tvalid === 1'b1 && m_tready) begin
            vectors++;
            if (out_i >= fout) begin
               miscompares++;
               $display("FAIL extra_output: got word %0d required at most %0d words", out_i + 1, fout);
            end else begin
               exp_d = src[src_index(out_i, w, cg)];
               if (obs_m_tdata !== exp_d || obs_m_tlast !== (out_i == fout - 1)) begin
                  miscompares++;
                  $display("FAIL out_word %0d: got data=%h last=%b required data=%h last=%b",
                           out_i, obs_m_tdata, obs_m_tlast, exp_d, (out_i == fout - 1));
               end
            end
            out_i++;
         end
         stalled = (obs_m_tvalid === 1'b1) && !m_tready;
         held = obs_m_tdata;
         cyc++;
      end
      vectors++;
      if (!got_done) begin
         miscompares++;
         $display("FAIL done_timeout: ap_done not seen in %0d cycles, required 1 pulse", budget);
      end
      vectors++;
      if (out_i != fout || in_i != fin) begin
         miscompares++;
         $display("FAIL word_counts: got in=%0d out=%0d required in=%0d out=%0d", in_i, out_i, fin, fout);
      end
      vectors++;
      if (nready != 1) begin
         miscompares++;
         $display("FAIL ap_ready_count: got %0d required 1", nready);
      end
      vectors++;
      if (done_cyc - rdy_cyc < 4 * w * cg) begin
         miscompares++;
         $display("FAIL ready_to_done: got %0d cycles required >= %0d", done_cyc - rdy_cyc, 4 * w * cg);
      end
      vectors++;
      if (obs_err !== exp_err) begin
         miscompares++;
         $display("FAIL err_tlast_final: got %b required %b", obs_err, exp_err);
      end
   endtask

   task automatic test_reset();
      ap_rst = 1'b1;
      repeat (3) @(negedge ap_clk);
      #1;
      vectors++;
      if ({obs_done, obs_idle, obs_ready, obs_s_tready, obs_m_tvalid, obs_m_tlast, obs_err} !== 7'b0100000
          || obs_m_tdata !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_values: got done/idle/ready/s_tready/m_tvalid/m_tlast/err=%b%b%b%b%b%b%b data=%h required 0100000 data=0",
                  obs_done, obs_idle, obs_ready, obs_s_tready, obs_m_tvalid, obs_m_tlast, obs_err, obs_m_tdata);
      end
      ap_rst = 1'b0;
   endtask

   task automatic test_basic();
      run_frame(0, 7, 100, 100, 0, 1, -1);
   endtask

   task automatic test_backpressure();
      run_frame(0, 7, 70, 30, 0, 1, -1);
      run_frame(0, 7, 50, 50, 0, 0, -1);
   endtask

   task automatic test_tlast_err();
      run_frame(0, 3, 100, 100, 0, 0, -1);
      run_frame(0, 7, 100, 100, 0, 0, -1);
   endtask

   task automatic test_reset_mid();
      run_frame(0, 7, 100, 100, 0, 1, 10);
      @(negedge ap_clk);
      #1;
      vectors++;
      if ({obs_done, obs_idle, obs_ready, obs_s_tready, obs_m_tvalid, obs_m_tlast, obs_err} !== 7'b0100000
          || obs_m_tdata !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_mid_frame: got done/idle/ready/s_tready/m_tvalid/m_tlast/err=%b%b%b%b%b%b%b data=%h required 0100000 data=0",
                  obs_done, obs_idle, obs_ready, obs_s_tready, obs_m_tvalid, obs_m_tlast, obs_err, obs_m_tdata);
      end
      ap_rst = 1'b0;
      run_frame(0, 7, 100, 100, 0, 1, -1);
   endtask

   task automatic test_start_held();
      run_frame(0, 7, 100, 100, 1, 0, -1);
      run_frame(0, 7, 100, 60, 0, 0, -1);
   endtask

   task automatic test_default_size();
      run_frame(1, 13 * 13 * 32 - 1, 100, 100, 0, 1, -1);
      sel = 1'b0;
   endtask

   initial begin
      ap_rst = 1'b1; ap_start = 1'b0; sel = 1'b0;
      s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_tlast_err();
      test_reset_mid();
      test_start_held();
      test_default_size();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/yolo_upsamp_stream.md
# yolo_upsamp_stream

RTL 2× nearest-neighbour upsampler for the Tiny YOLO v3 route branch (13×13 → 26×26 feature map), driven by the same ap_start/ap_done/ap_idle/ap_ready block protocol as the HLS stage it replaces.
- Sits directly downstream of the 1×1 convolution stream and feeds the concat/route stage.
- Consumes an AXI4-Stream of channel-group words in raster order, buffers one input row, and emits each row twice with each pixel duplicated horizontally.
- Exposes the same control handshake so the existing dataflow module/loop monitors attach unchanged.

## Interface
Parameters:
- DATA_W, 64: bits per stream word (4 channels × 16-bit fixed point)
- IMG_W, 13: input width in pixels
- IMG_H, 13: input height in pixels
- CG, 32: channel-group words per pixel

Ports:
- ap_clk  in  1  clock; the block has one clock
- ap_rst  in  1  reset, synchronous, active-high
- ap_start  in  1  start one frame; sampled in IDLE only
- ap_done  out  1  one-cycle pulse, frame fully emitted
- ap_idle  out  1  high in IDLE
- ap_ready  out  1  one-cycle pulse, last input word of frame accepted
- s_tdata  in  DATA_W  input word
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- s_tlast  in  1  input end-of-frame marker
- m_tdata  out  DATA_W  output word
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- m_tlast  out  1  high on final output word of frame
- err_tlast  out  1  sticky: s_tlast mismatched expected position

## Operation
- States: IDLE, FILL, EMIT_A, EMIT_B, DONE.
- IDLE:
  - ap_idle=1.
  - ap_start=1 → FILL; clear err_tlast, row=0, wr_idx=0.
- FILL:
  - s_tready=1; each accepted word is written to line buffer at wr_idx, then wr_idx++.
  - On accepting word IMG_W*CG-1 → EMIT_A, wr_idx=0.
  - If row==IMG_H-1, also pulse ap_ready on that acceptance.
- EMIT_A / EMIT_B:
  - Read order: for c in 0..IMG_W-1, rep in 0..1, g in 0..CG-1, addr=c*CG+g.
  - Read address advances only when the output stage has a free slot.
  - After the last read of EMIT_A → EMIT_B. After the last output word of EMIT_B is accepted:
    - row<IMG_H-1 → row++, FILL.
    - else → DONE.
- DONE: pulse ap_done for one cycle → IDLE.
- s_tready=0 outside FILL. ap_start outside IDLE is ignored.
- m_tlast asserts on output word index 4*IMG_W*IMG_H*CG-1 only.
- err_tlast:
  - Set if s_tlast=1 on any accepted word other than frame word IMG_W*IMG_H*CG-1, or s_tlast=0 on that word.
  - Data flow continues by count regardless.
- Counters are sized with $clog2 of their terminal count +1; row, col, g and rep wrap to 0 at their terminal values.

## Timing
- Reset values: ap_done=0, ap_idle=1, ap_ready=0, s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, err_tlast=0; state=IDLE.
  - Reset mid-frame aborts immediately. The next frame starts clean; line buffer contents are don't-care.
- Line buffer read latency is 1 cycle. First m_tvalid occurs 2 cycles after FILL→EMIT_A.
- With m_tready held high, throughput is 1 word/cycle within EMIT_A/EMIT_B.
- Output stage is 2 entries deep. m_tdata/m_tvalid/m_tlast stay stable while m_tvalid&&!m_tready, with no loss or duplication under any backpressure pattern.
- EMIT_B→FILL happens only after the output stage drains. s_tready rises the cycle after.
- ap_done pulses 1 cycle after the final m_tvalid&&m_tready handshake.
- ap_ready precedes ap_done by at least 2*2*IMG_W*CG cycles.

## Structure
- Package yolo_upsamp_pkg: state enum; localparams ROW_WORDS=IMG_W*CG, FRAME_IN=ROW_WORDS*IMG_H, FRAME_OUT=4*FRAME_IN; address and counter width functions.
- Sub-module upsamp_line_buf: simple dual-port RAM, depth ROW_WORDS, width DATA_W, registered read, one write and one read port.
- FSM, counters, tlast checker and 2-entry output stage live in the top.

## Test plan
- IMG_W=2, IMG_H=2, CG=2; input 0..7, s_tlast on 7, m_tready=1 → output 0,1,0,1,2,3,2,3 twice, then 4,5,4,5,6,7,6,7 twice. 32 words, m_tlast on word 31 only, ap_ready once, ap_done once, err_tlast=0.
- Same stimulus with m_tready random at 30% → identical 32-word sequence, m_tdata stable during every stall.
- s_tlast asserted on input word 3 → err_tlast=1 from that cycle until next ap_start. Output still 32 words.
- ap_rst pulsed during EMIT_B of row 0 → all outputs at reset values next cycle. A following full frame reproduces scenario 1 exactly.
- ap_start held high through a frame → exactly one frame is processed. A second frame starts only from IDLE, with ap_idle=1 for at least 1 cycle between frames.
- Default parameters, 13×13×32 ramp input → 26×26×32 = 21632 output words; checker compares against the nearest-neighbour golden model.
